pe_mem_loader: RTL and testbench
================================

Name: pe_mem_loader

Overview:
Upstream feeder for a single PE's local data memory. Before a sort/compute run, it clears the PE memory and then streams DEPTH = 2**ADDR_WIDTH words into it over a valid/ready input. It drives the PE's memory write port and rst_memory input. It then signals completion so the sequencer can release the PE into its SORT_CYCLES/COMPUTE_CYCLES phases.

Parameters:
DATA_WIDTH, 32, width of one memory word
ADDR_WIDTH, 3, PE memory address width; DEPTH = 2**ADDR_WIDTH
CLEAR_ON_START, 1, 1 = run a zero-fill pass before loading; 0 = go straight to LOAD

Ports:
clk  in  1  clock; all state changes on the rising edge
rst  in  1  reset, asynchronous, active-low
i_start  in  1  one-cycle request to begin a load; sampled only in IDLE or DONE
i_valid  in  1  input word valid
i_data  in  DATA_WIDTH  input word
o_ready  out  1  loader accepts a word this cycle
o_mem_we  out  1  PE memory write enable, registered
o_mem_addr  out  ADDR_WIDTH  PE memory write address, registered
o_mem_data  out  DATA_WIDTH  PE memory write data, registered
o_rst_memory  out  1  high for the whole CLEAR state; drives PE rst_memory
o_busy  out  1  high in CLEAR or LOAD
o_done  out  1  load complete; held until the next start or reset
o_count  out  ADDR_WIDTH+1  words accepted in the current load, 0..DEPTH

Behaviour:
- Reset (rst=0, async):
  - State goes to IDLE immediately.
  - All outputs are 0 and the internal counter is 0.
  - Reset during CLEAR or LOAD aborts the operation: no further writes and o_done stays 0.
- States: IDLE, CLEAR, LOAD, DONE.
- IDLE:
  - o_ready=0 and o_mem_we=0.
  - On i_start=1: counter <= 0; next state is CLEAR if CLEAR_ON_START=1, otherwise LOAD.
- CLEAR:
  - o_rst_memory=1.
  - Each cycle registers one write: we=1, addr=counter[ADDR_WIDTH-1:0], data=0.
  - Runs for exactly DEPTH cycles, covering addresses 0..DEPTH-1 in order.
  - Then counter <= 0 and the state goes to LOAD.
  - o_ready=0 and o_count=0 throughout.
- LOAD:
  - o_ready = (counter < DEPTH); this is a combinational decode of state and counter.
  - Handshake is i_valid & o_ready sampled at a rising edge.
  - On a handshake, the next cycle shows o_mem_we=1, o_mem_addr=counter[ADDR_WIDTH-1:0], o_mem_data=i_data, and counter increments.
  - Write latency is 1 cycle; o_mem_we is 0 in any cycle that follows no handshake.
  - Gaps in i_valid are allowed. Order is preserved and addresses stay contiguous.
  - On the handshake that brings the counter to DEPTH, the state goes to DONE at the same edge, so o_ready is low from the next cycle.
- DONE:
  - o_done rises one edge after the final write becomes visible, i.e. on the edge where the memory commits the last word.
  - o_count=DEPTH and o_ready=0.
  - i_start=1 clears o_done and o_count on the next edge and re-enters CLEAR or LOAD as in IDLE.
- Boundary rules:
  - i_start in CLEAR or LOAD is ignored.
  - i_valid outside LOAD, or with counter=DEPTH, is ignored.
  - The address wraps naturally from DEPTH-1 to 0 between passes; the counter never exceeds DEPTH.
  - i_start and i_valid high in the same IDLE cycle: only the start is taken, no word is accepted.
  - o_busy = (state==CLEAR) | (state==LOAD).
- Widths: the counter is ADDR_WIDTH+1 bits, so DEPTH is representable.

Test Plan:
1. Reset then i_start with CLEAR_ON_START=1, ADDR_WIDTH=3 -> o_rst_memory high for 8 cycles; writes to addr 0..7 with data 0; o_ready rises the cycle after CLEAR ends.
2. Continuous i_valid with data 0x10..0x17 -> one write per cycle, addr 0..7 in order, each 1 cycle after its handshake; o_done=1 one edge after the addr-7 write; o_count=8; o_ready=0.
3. i_valid toggling 1,0,1,0 with data 0xA0..0xA7 -> exactly 8 writes in order with no skipped addresses; o_mem_we low in the cycles after each gap.
4. Assert rst=0 asynchronously mid-cycle after 3 words -> outputs go to 0 at once; after release, IDLE with o_done=0 and o_count=0; a new start restarts from addr 0.
5. i_start pulsed during LOAD, and i_valid held during CLEAR and DONE -> no state change, no extra writes, o_count unaffected.
6. In DONE, pulse i_start with CLEAR_ON_START=0 -> o_done=0 next edge, LOAD entered directly, no o_rst_memory pulse, reload writes start at addr 0.

Source files
------------

// File: rtl/pe_mem_loader.sv
// Upstream feeder for one PE's local data memory: optional zero-fill pass,
// then streams DEPTH words from a valid/ready input into the memory write port.
module pe_mem_loader #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 3,
    parameter bit CLEAR_ON_START = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    input  logic                  i_valid,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_ready,
    output logic                  o_mem_we,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [DATA_WIDTH-1:0] o_mem_data,
    output logic                  o_rst_memory,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [ADDR_WIDTH:0]   o_count
);

    localparam int                DEPTH   = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] LAST_C  = (ADDR_WIDTH + 1)'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        LOAD  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam state_t START_STATE = CLEAR_ON_START ? CLEAR : LOAD;

    state_t              state;
    logic [ADDR_WIDTH:0] counter;
    logic                handshake;

    // Counter doubles as the zero-fill address in CLEAR, so o_count is masked there.
    assign o_ready      = (state == LOAD) && (counter < DEPTH_C);
    assign handshake    = i_valid & o_ready;
    assign o_rst_memory = (state == CLEAR);
    assign o_busy       = (state == CLEAR) || (state == LOAD);
    assign o_count      = ((state == LOAD) || (state == DONE)) ? counter : '0;

    // NOTE: all state here is sequential, so every assignment in this block is
    // non-blocking; blocking ones would let later statements see same-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            counter    <= '0;
            o_mem_we   <= 1'b0;
            o_mem_addr <= '0;
            o_mem_data <= '0;
            o_done     <= 1'b0;
        end else begin
            // Write strobe and done are pulses/levels recomputed every edge.
            o_mem_we <= 1'b0;
            o_done   <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_start) begin
                        counter <= '0;
                        state   <= START_STATE;
                    end
                end
                CLEAR: begin
                    o_mem_we   <= 1'b1;
                    o_mem_addr <= counter[ADDR_WIDTH-1:0];
                    o_mem_data <= '0;
                    if (counter == LAST_C) begin
                        counter <= '0;
                        state   <= LOAD;
                    end else begin
                        counter <= counter + 1'b1;
                    end
                end
                LOAD: begin
                    if (handshake) begin
                        o_mem_we   <= 1'b1;
                        o_mem_addr <= counter[ADDR_WIDTH-1:0];
                        o_mem_data <= i_data;
                        counter    <= counter + 1'b1;
                        if (counter == LAST_C) state <= DONE;
                    end
                end
                DONE: begin
                    // o_done trails the last write by one edge: memory commit point.
                    if (i_start) begin
                        counter <= '0;
                        state   <= START_STATE;
                    end else begin
                        o_done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pe_mem_loader.sv
// Bench for pe_mem_loader: two instances (with and without zero-fill) checked
// every cycle against a transaction-level model, plus directed literal checks.
module tb_pe_mem_loader;

    localparam int DW    = 32;
    localparam int AW    = 3;
    localparam int DEPTH = 8;

    logic clk;
    logic rst;
    logic [1:0]    start, valid;
    logic [DW-1:0] din [2];
    logic [1:0]    ready, we, rstm, busy, done;
    logic [AW-1:0] addr [2];
    logic [DW-1:0] dout [2];
    logic [AW:0]   cnt [2];

    int n_vec = 0;
    int n_err = 0;

    pe_mem_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CLEAR_ON_START(1'b1)) u_clr (
        .clk(clk), .rst(rst), .i_start(start[0]), .i_valid(valid[0]), .i_data(din[0]),
        .o_ready(ready[0]), .o_mem_we(we[0]), .o_mem_addr(addr[0]), .o_mem_data(dout[0]),
        .o_rst_memory(rstm[0]), .o_busy(busy[0]), .o_done(done[0]), .o_count(cnt[0])
    );

    pe_mem_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CLEAR_ON_START(1'b0)) u_direct (
        .clk(clk), .rst(rst), .i_start(start[1]), .i_valid(valid[1]), .i_data(din[1]),
        .o_ready(ready[1]), .o_mem_we(we[1]), .o_mem_addr(addr[1]), .o_mem_data(dout[1]),
        .o_rst_memory(rstm[1]), .o_busy(busy[1]), .o_done(done[1]), .o_count(cnt[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: run did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Model: phase (0 idle, 1 zero-fill, 2 loading, 3 finished), words taken,
    // fill words left, and the write that must appear on the port this cycle.
    typedef struct {
        int          mode;
        int          n;
        int          clr_left;
        bit          we;
        int          addr;
        logic [31:0] data;
        bit          done;
    } mdl_t;

    mdl_t        m [2];
    logic [31:0] mem_img [2][DEPTH];
    int          wr_cnt [2];

    function automatic mdl_t mdl_zero();
        mdl_t z;
        z.mode = 0; z.n = 0; z.clr_left = 0; z.we = 0; z.addr = 0; z.data = '0; z.done = 0;
        return z;
    endfunction

    function automatic mdl_t step(input mdl_t s, input bit clr_en, input logic st,
                                  input logic vl, input logic [31:0] d);
        mdl_t r = s;
        r.we   = 0;
        r.done = (s.mode == 3) && !st;
        if ((s.mode == 0 || s.mode == 3) && st) begin
            r.mode     = clr_en ? 1 : 2;
            r.n        = 0;
            r.clr_left = clr_en ? DEPTH : 0;
        end else if (s.mode == 1) begin
            r.we = 1; r.addr = DEPTH - s.clr_left; r.data = '0;
            r.clr_left = s.clr_left - 1;
            if (r.clr_left == 0) r.mode = 2;
        end else if (s.mode == 2 && vl && s.n < DEPTH) begin
            r.we = 1; r.addr = s.n; r.data = d;
            r.n = s.n + 1;
            if (r.n == DEPTH) r.mode = 3;
        end
        return r;
    endfunction

    initial begin
        for (int k = 0; k < 2; k++) begin
            m[k] = mdl_zero();
            wr_cnt[k] = 0;
            for (int a = 0; a < DEPTH; a++) mem_img[k][a] = 32'hDEAD_BEEF;
        end
        forever begin
            @(posedge clk);
            for (int k = 0; k < 2; k++)
                m[k] = !rst ? mdl_zero() : step(m[k], k == 0, start[k], valid[k], din[k]);
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (!rst) m[k] = mdl_zero();
                check($sformatf("u%0d_ready", k), ready[k], (m[k].mode == 2 && m[k].n < DEPTH));
                check($sformatf("u%0d_rst_memory", k), rstm[k], m[k].mode == 1);
                check($sformatf("u%0d_busy", k), busy[k], m[k].mode == 1 || m[k].mode == 2);
                check($sformatf("u%0d_done", k), done[k], m[k].done);
                check($sformatf("u%0d_count", k), cnt[k], (m[k].mode >= 2) ? m[k].n : 0);
                check($sformatf("u%0d_we", k), we[k], m[k].we);
                if (m[k].we) begin
                    check($sformatf("u%0d_addr", k), addr[k], m[k].addr);
                    check($sformatf("u%0d_data", k), dout[k], m[k].data);
                end
                if (rst && we[k]) begin
                    mem_img[k][addr[k]] = dout[k];
                    wr_cnt[k]++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input int k);
        int guard = 0;
        while (!ready[k] && guard < 30) begin
            tick();
            guard++;
        end
        check($sformatf("u%0d_wait_ready_in_budget", k), ready[k], 1'b1);
    endtask

    task automatic check_mem(input int k, input logic [31:0] base, input logic [31:0] stride);
        for (int a = 0; a < DEPTH; a++)
            check($sformatf("u%0d_mem[%0d]", k, a), mem_img[k][a], base + stride * a);
    endtask

    initial begin
        int clr_cycles;
        int snap;
        start = '0; valid = '0; din[0] = '0; din[1] = '0;
        rst = 1'b1;
        #1 rst = 1'b0;
        #1;
        check("reset_we", we[0], 0);
        check("reset_ready", ready[0], 0);
        check("reset_done", done[0], 0);
        check("reset_count", cnt[0], 0);
        check("reset_addr", addr[0], 0);
        check("reset_data", dout[0], 0);
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b1;
        tick();

        // 1: zero-fill pass, ready rises right after it
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        clr_cycles = 0;
        for (int g = 0; g < 20 && !ready[0]; g++) begin
            if (rstm[0]) clr_cycles++;
            tick();
        end
        check("t1_clear_cycles", clr_cycles, 8);
        check("t1_ready_after_clear", ready[0], 1);
        @(negedge clk); #1;
        check_mem(0, 32'h0, 32'h0);
        tick();

        // 2: continuous stream 0x10..0x17
        for (int i = 0; i < 8; i++) begin
            valid[0] = 1'b1;
            din[0]   = 32'h10 + i;
            tick();
        end
        valid[0] = 1'b0;
        check("t2_last_we", we[0], 1);
        check("t2_last_addr", addr[0], 7);
        check("t2_last_data", dout[0], 32'h17);
        check("t2_done_not_yet", done[0], 0);
        check("t2_ready_low", ready[0], 0);
        tick();
        check("t2_done", done[0], 1);
        check("t2_count", cnt[0], 8);
        @(negedge clk); #1;
        check_mem(0, 32'h10, 32'h1);

        // 3: restart from DONE, gapped stream 0xA0..0xA7
        snap = wr_cnt[0];
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        check("t3_done_cleared", done[0], 0);
        wait_ready(0);
        for (int i = 0; i < 16; i++) begin
            valid[0] = (i % 2 == 0);
            din[0]   = 32'hA0 + i / 2;
            tick();
        end
        valid[0] = 1'b0;
        check("t3_done", done[0], 1);
        @(negedge clk); #1;
        check("t3_write_count", wr_cnt[0] - snap, 16);
        check_mem(0, 32'hA0, 32'h1);

        // 4: async reset mid-cycle after three words
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        wait_ready(0);
        for (int i = 0; i < 3; i++) begin
            valid[0] = 1'b1;
            din[0]   = 32'h30 + i;
            tick();
        end
        valid[0] = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("t4_rst_we", we[0], 0);
        check("t4_rst_busy", busy[0], 0);
        check("t4_rst_count", cnt[0], 0);
        check("t4_rst_addr", addr[0], 0);
        check("t4_rst_data", dout[0], 0);
        @(posedge clk);
        #3 rst = 1'b1;
        tick();
        check("t4_idle_done", done[0], 0);
        check("t4_idle_count", cnt[0], 0);
        check("t4_idle_busy", busy[0], 0);

        // 5: start+valid in IDLE, valid held through CLEAR/DONE, start in LOAD
        valid[0] = 1'b1;
        din[0]   = 32'h50;
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        check("t5_in_clear", rstm[0], 1);
        check("t5_no_word_taken", we[0], 0);
        wait_ready(0);
        for (int i = 0; i < 8; i++) begin
            din[0]   = 32'h50 + i;
            start[0] = (i == 3);
            tick();
            if (i == 0) begin
                check("t5_first_addr", addr[0], 0);
                check("t5_first_data", dout[0], 32'h50);
            end
        end
        start[0] = 1'b0;
        check("t5_count_full", cnt[0], 8);
        repeat (4) tick();
        check("t5_done_held", done[0], 1);
        check("t5_count_held", cnt[0], 8);
        check("t5_no_extra_write", we[0], 0);
        valid[0] = 1'b0;
        @(negedge clk); #1;
        check_mem(0, 32'h50, 32'h1);

        // 6: no zero-fill instance, reload from DONE
        start[1] = 1'b1;
        tick();
        start[1] = 1'b0;
        check("t6_direct_load", ready[1], 1);
        check("t6_no_rst_memory", rstm[1], 0);
        for (int i = 0; i < 8; i++) begin
            valid[1] = 1'b1;
            din[1]   = 32'h60 + i;
            tick();
        end
        valid[1] = 1'b0;
        tick();
        check("t6_done", done[1], 1);
        @(negedge clk); #1;
        check_mem(1, 32'h60, 32'h1);
        start[1] = 1'b1;
        tick();
        start[1] = 1'b0;
        check("t6_done_cleared", done[1], 0);
        check("t6_count_cleared", cnt[1], 0);
        check("t6_reload_ready", ready[1], 1);
        check("t6_reload_no_rst_memory", rstm[1], 0);
        valid[1] = 1'b1;
        din[1]   = 32'h70;
        tick();
        check("t6_reload_addr", addr[1], 0);
        check("t6_reload_data", dout[1], 32'h70);
        for (int i = 1; i < 8; i++) begin
            din[1] = 32'h70 + i;
            tick();
        end
        valid[1] = 1'b0;
        tick();
        check("t6_reload_done", done[1], 1);
        @(negedge clk); #1;
        check_mem(1, 32'h70, 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
